// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC, loadable word-addressed instruction memory, IF/ID register and RUN/HALT fault FSM.
// One cycle PC -> IF/ID; pc_write/ifid_write stall the stage, flush squashes IF/ID, a bad fetch halts until reset.
module if_stage_param #(
  parameter int               AW       = 32,
  parameter int               IW       = 32,
  parameter int               DEPTH    = 64,
  parameter logic [AW-1:0]    RESET_PC = '0,
  parameter logic [IW-1:0]    NOP      = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pc_write,
  input  logic                     ifid_write,
  input  logic                     flush,
  input  logic                     pc_src,
  input  logic [AW-1:0]            branch_addr,
  input  logic                     jump,
  input  logic [AW-1:0]            jump_addr,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [IW-1:0]            load_data,
  output logic [AW-1:0]            pc_out,
  output logic [IW-1:0]            instr_id,
  output logic [AW-1:0]            pc_id,
  output logic [AW-1:0]            pc_plus4_id,
  output logic                     valid_id,
  output logic                     fault,
  output logic                     halted
);

  localparam int            IDXW    = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_id_q, pc_id_d;
  logic [AW-1:0] pc4_id_q, pc4_id_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;

  logic [IW-1:0] mem_q [DEPTH];

  logic          fetch_bad;
  logic [IW-1:0] fetch_word;
  logic [AW-1:0] pc_plus4;

  // Out-of-range or misaligned PC must never index the array; the word is replaced by NOP.
  assign fetch_bad  = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[AW-1:2]} >= DEPTH_A);
  assign fetch_word = fetch_bad ? NOP : mem_q[pc_q[IDXW+1:2]];
  assign pc_plus4   = pc_q + AW'(4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_id_d  = pc_id_q;
    pc4_id_d = pc4_id_q;
    valid_d  = valid_q;
    fault_d  = fault_q;

    if (flush || (ifid_write && (state_q == HALT || fetch_bad))) begin
      instr_d  = NOP;
      pc_id_d  = '0;
      pc4_id_d = '0;
      valid_d  = 1'b0;
    end else if (ifid_write) begin
      instr_d  = fetch_word;
      pc_id_d  = pc_q;
      pc4_id_d = pc_plus4;
      valid_d  = 1'b1;
    end

    // A bad fetch only faults when it would actually enter IF/ID; wrong-path fetches redirect normally.
    if (state_q == RUN) begin
      if (fetch_bad && ifid_write && !flush) begin
        state_d = HALT;
        fault_d = 1'b1;
      end else if (!pc_write) begin
        pc_d = pc_q;
      end else if (jump) begin
        pc_d = jump_addr;
      end else if (pc_src) begin
        pc_d = branch_addr;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      pc_id_q  <= '0;
      pc4_id_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      pc4_id_q <= pc4_id_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  // Memory is never cleared by reset and keeps accepting loads in every state.
  always_ff @(posedge clock) begin
    if (load_en && (32'(load_addr) < DEPTH)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign pc_out      = pc_q;
  assign instr_id    = instr_q;
  assign pc_id       = pc_id_q;
  assign pc_plus4_id = pc4_id_q;
  assign valid_id    = valid_q;
  assign fault       = fault_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_if_stage_param.sv
// Directed bench for if_stage_param: fetch sequence, redirect priority, stall/flush, load port and fault/halt.
// Inputs change 1 ns after each rising edge; outputs are compared at the same point.
module tb_if_stage_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_write, ifid_write, flush, pc_src, jump, load_en;
  logic [31:0] branch_addr, jump_addr, load_data;
  logic [5:0]  load_addr;
  logic [31:0] pc_out, instr_id, pc_id, pc_plus4_id;
  logic        valid_id, fault, halted;

  int n_chk  = 0;
  int n_pass = 0;

  if_stage_param dut (
    .clock       (clock),
    .reset       (reset),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .flush       (flush),
    .pc_src      (pc_src),
    .branch_addr (branch_addr),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .pc_out      (pc_out),
    .instr_id    (instr_id),
    .pc_id       (pc_id),
    .pc_plus4_id (pc_plus4_id),
    .valid_id    (valid_id),
    .fault       (fault),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0;
    pc_src = 1'b0; jump = 1'b0; load_en = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic v);
    chk({tag, ".instr"}, instr_id, ins);
    chk({tag, ".pc_id"}, pc_id, pc);
    chk({tag, ".pc4"}, pc_plus4_id, v ? pc + 32'd4 : 32'd0);
    chk({tag, ".valid"}, 32'(valid_id), 32'(v));
  endtask

  logic [5:0]  ld_idx [9];
  logic [31:0] ld_dat [9];

  initial begin
    ld_idx = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd14, 6'd63};
    ld_dat = '{32'h20080020, 32'h20090037, 32'h01098024, 32'h01098025,
               32'h00000044, 32'h00000055, 32'h00000066, 32'h000000E0, 32'hFFFF0063};
    idle();
    branch_addr = '0; jump_addr = '0; load_addr = '0; load_data = '0;
    reset = 1'b1;
    #1;
    // Program is loaded while reset is held.
    for (int i = 0; i < 9; i++) begin
      load_en = 1'b1; load_addr = ld_idx[i]; load_data = ld_dat[i];
      tick();
    end
    load_en = 1'b0;
    chk("rst.pc", pc_out, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    reset = 1'b0;

    tick(); chk("seq.pc4", pc_out, 32'h4);  chk_ifid("seq0", 32'h20080020, 32'h0, 1'b1);
    tick(); chk("seq.pc8", pc_out, 32'h8);  chk_ifid("seq1", 32'h20090037, 32'h4, 1'b1);
    tick(); chk("seq.pc12", pc_out, 32'hC); chk_ifid("seq2", 32'h01098024, 32'h8, 1'b1);

    pc_src = 1'b1; branch_addr = 32'h8;
    tick(); chk("br.pc", pc_out, 32'h8); chk_ifid("seq3", 32'h01098025, 32'hC, 1'b1);

    jump = 1'b1; jump_addr = 32'h38; pc_src = 1'b1; branch_addr = 32'h20;
    tick(); chk("jmp_wins.pc", pc_out, 32'h38); chk_ifid("refetch8", 32'h01098024, 32'h8, 1'b1);

    jump = 1'b0; pc_src = 1'b1; branch_addr = 32'h10;
    tick(); chk("br2.pc", pc_out, 32'h10); chk_ifid("at38", 32'hE0, 32'h38, 1'b1);

    idle();
    tick(); chk("pc14", pc_out, 32'h14); chk_ifid("at10", 32'h44, 32'h10, 1'b1);

    pc_write = 1'b0; ifid_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); chk("stall.pc", pc_out, 32'h14); chk_ifid("stall", 32'h44, 32'h10, 1'b1);
    end

    flush = 1'b1;
    tick(); chk("flush.pc", pc_out, 32'h14); chk_ifid("flush", 32'h0, 32'h0, 1'b0);

    // Write index 5 while PC=0x14 fetches it: IF/ID must see the old word.
    idle();
    load_en = 1'b1; load_addr = 6'd5; load_data = 32'hDEADBEEF;
    tick(); chk("ld.pc", pc_out, 32'h18); chk_ifid("ld_old", 32'h55, 32'h14, 1'b1);

    idle(); pc_src = 1'b1; branch_addr = 32'h14;
    tick(); chk("ld.back", pc_out, 32'h14); chk_ifid("at18", 32'h66, 32'h18, 1'b1);
    idle();
    tick(); chk_ifid("ld_new", 32'hDEADBEEF, 32'h14, 1'b1);

    jump = 1'b1; jump_addr = 32'hFC;
    tick(); chk("pcFC", pc_out, 32'hFC);
    idle();
    tick(); chk("pc100", pc_out, 32'h100); chk_ifid("lastword", 32'hFFFF0063, 32'hFC, 1'b1);
    chk("lastword.fault", 32'(fault), 32'd0);
    tick(); chk("oob.fault", 32'(fault), 32'd1); chk("oob.halted", 32'(halted), 32'd1);
    chk("oob.pc", pc_out, 32'h100); chk_ifid("oob", 32'h0, 32'h0, 1'b0);

    jump = 1'b1; jump_addr = 32'h0;
    tick(); chk("halt.jmp_pc", pc_out, 32'h100); chk("halt.stays", 32'(halted), 32'd1);
    chk("halt.fault", 32'(fault), 32'd1);

    idle(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rst2.pc", pc_out, 32'h0); chk("rst2.fault", 32'(fault), 32'd0);
    chk("rst2.halted", 32'(halted), 32'd0);

    jump = 1'b1; jump_addr = 32'h100;
    tick(); chk("wp.pc", pc_out, 32'h100);
    jump = 1'b1; jump_addr = 32'h0; flush = 1'b1;
    tick(); chk("wp.fault", 32'(fault), 32'd0); chk("wp.halted", 32'(halted), 32'd0);
    chk("wp.pc", pc_out, 32'h0); chk("wp.valid", 32'(valid_id), 32'd0);

    idle(); jump = 1'b1; jump_addr = 32'h6;
    tick(); chk("mis.pc", pc_out, 32'h6); chk("mis.fault0", 32'(fault), 32'd0);
    chk_ifid("mis.at0", 32'h20080020, 32'h0, 1'b1);
    idle();
    tick(); chk("mis.fault", 32'(fault), 32'd1); chk("mis.halted", 32'(halted), 32'd1);
    chk("mis.pc_hold", pc_out, 32'h6); chk("mis.valid", 32'(valid_id), 32'd0);

    // Loads are still accepted while halted.
    load_en = 1'b1; load_addr = 6'd7; load_data = 32'h00000077;
    tick(); load_en = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    jump = 1'b1; jump_addr = 32'h1C;
    tick(); chk("hl.pc", pc_out, 32'h1C);
    idle();
    tick(); chk_ifid("hl.load", 32'h77, 32'h1C, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
